// File: rtl/axis_pl_to_ps_if.sv
// AXI-Stream bundle shared by the wide input side and the narrow output side
// of the PL-to-PS down-converter; tlast is only meaningful toward the PS.
interface axis_pl_to_ps_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_pl_to_ps.sv
// Serializes wide ADC capture beats into PS-width words, lowest lane first,
// framing the output with tlast and flushing whenever the channel selection changes.
module axis_pl_to_ps #(
  parameter int IN_WIDTH    = 128,
  parameter int OUT_WIDTH   = 32,
  parameter int FRAME_BEATS = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [15:0]           i_channel_select,
  axis_pl_to_ps_if.slave        s_axis,
  axis_pl_to_ps_if.master       m_axis,
  output logic [15:0]           o_frame_count
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WCNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_BEATS - 1);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2 || FRAME_BEATS < 1) begin : g_bad_params
      $error("axis_pl_to_ps: IN_WIDTH must be >= 2x and a multiple of OUT_WIDTH, FRAME_BEATS >= 1");
    end
  endgenerate

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [IN_WIDTH-1:0]   r_hold;
  logic [IN_WIDTH-1:0]   w_hold_n;
  logic [LANE_W-1:0]     r_lane;
  logic [LANE_W-1:0]     w_lane_n;
  logic [WCNT_W-1:0]     r_wcnt;
  logic [WCNT_W-1:0]     w_wcnt_n;
  logic [15:0]           r_frame_count;
  logic [15:0]           w_frame_count_n;
  logic [15:0]           r_sel_q;

  logic w_full;
  logic w_last_lane;
  logic w_flush;
  logic w_in_hs;
  logic w_out_hs;
  logic w_load;
  logic w_tlast;

  assign w_full      = (r_state == DRAIN);
  assign w_last_lane = (r_lane == LAST_LANE);
  assign w_flush     = (i_channel_select != r_sel_q);
  assign w_tlast     = w_full & (r_wcnt == LAST_WORD);

  // Ready looks through to the PS on the last lane so beats chain without a bubble.
  assign s_axis.tready = !w_full | (m_axis.tready & w_last_lane);
  assign m_axis.tvalid = w_full;
  assign m_axis.tdata  = r_hold[int'(r_lane) * OUT_WIDTH +: OUT_WIDTH];
  assign m_axis.tlast  = w_tlast;
  assign o_frame_count = r_frame_count;

  assign w_in_hs  = s_axis.tvalid & s_axis.tready;
  assign w_out_hs = w_full & m_axis.tready;
  // Beats arriving during a flush or while no channel is selected are dropped.
  assign w_load   = w_in_hs & !w_flush & (i_channel_select != 16'd0);

  always_comb begin
    w_state_n       = r_state;
    w_hold_n        = r_hold;
    w_lane_n        = r_lane;
    w_wcnt_n        = r_wcnt;
    w_frame_count_n = r_frame_count;

    if (w_out_hs) begin
      if (w_tlast) begin
        w_wcnt_n        = '0;
        w_frame_count_n = r_frame_count + 16'd1;
      end else begin
        w_wcnt_n = r_wcnt + 1'b1;
      end
    end

    case (r_state)
      EMPTY: begin
        if (w_load) begin
          w_state_n = DRAIN;
          w_hold_n  = s_axis.tdata;
          w_lane_n  = '0;
        end
      end
      DRAIN: begin
        if (w_out_hs) begin
          if (!w_last_lane) begin
            w_lane_n = r_lane + 1'b1;
          end else if (w_load) begin
            w_hold_n = s_axis.tdata;
            w_lane_n = '0;
          end else begin
            w_state_n = EMPTY;
          end
        end
      end
      default: w_state_n = EMPTY;
    endcase

    // A channel change abandons the partial beat and restarts framing.
    if (w_flush) begin
      w_state_n = EMPTY;
      w_lane_n  = '0;
      w_wcnt_n  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= EMPTY;
      r_hold        <= '0;
      r_lane        <= '0;
      r_wcnt        <= '0;
      r_frame_count <= '0;
      r_sel_q       <= i_channel_select;
    end else begin
      r_state       <= w_state_n;
      r_hold        <= w_hold_n;
      r_lane        <= w_lane_n;
      r_wcnt        <= w_wcnt_n;
      r_frame_count <= w_frame_count_n;
      r_sel_q       <= i_channel_select;
    end
  end

endmodule

// File: doc/axis_pl_to_ps.md
# axis_pl_to_ps

Down-converting AXI-Stream bridge that carries ADC capture data from the PL back to the PS. It accepts wide beats (default 128 bits) from the selected ADC readout path and serializes each one into `ps_axis_width` words for the PS DMA, lowest lane first. It is the PL-to-PS counterpart of the PS-to-PL up-converter. It also frames the output stream with `tlast` and flushes cleanly when `channel_select` changes.

## Interface
- `IN_WIDTH`, 128: input beat width. Must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, `ps_axis_width` (32): output word width.
- `FRAME_BEATS`, 1024: output words per frame. `tlast` asserts on the last word of each frame. Must be ≥ 1.
- `RATIO` (localparam) = `IN_WIDTH/OUT_WIDTH`. Must be ≥ 2.

Ports (clock and reset first):
- `clk` in 1: single PL clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `channel_select` in 16: one-hot channel select from the channel selector. Any change of value triggers a flush.
- `s_axis_tdata` in `IN_WIDTH`: wide beat from the ADC mux.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `m_axis_tdata` out `OUT_WIDTH`: word to the PS.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready from the PS.
- `m_axis_tlast` out 1: last word of a frame.
- `frame_count` out 16: number of completed frames; wraps modulo 2^16.

## Operation
- Holding register `hold` (`IN_WIDTH`), flag `full`, lane counter `lane` (clog2(`RATIO`) bits), word counter `wcnt` (clog2(`FRAME_BEATS`) bits, minimum 1), and registered `sel_q` (previous `channel_select`).
- States: EMPTY (`full`=0) and DRAIN (`full`=1).
- EMPTY → DRAIN: on an input handshake, load `hold` with `s_axis_tdata` and set `lane`=0.
- DRAIN:
  - `m_axis_tdata` = `hold[lane*OUT_WIDTH +: OUT_WIDTH]`.
  - On an output handshake with `lane`<`RATIO`-1: `lane`++.
  - On an output handshake with `lane`=`RATIO`-1: if an input handshake occurs in the same cycle, reload `hold` and set `lane`=0 (stay in DRAIN); otherwise go to EMPTY.
- `s_axis_tready` = !`full` | (`m_axis_tready` & `lane`==`RATIO`-1). This is a combinational path from `m_axis_tready`, required for full throughput.
- `m_axis_tvalid` = `full`. Once asserted, `tvalid`/`tdata` stay stable until the handshake. The only exception is a flush.
- Framing:
  - `m_axis_tlast` = `full` & (`wcnt`==`FRAME_BEATS`-1).
  - Each output handshake increments `wcnt`; it wraps to 0 after `tlast`.
  - Each `tlast` handshake increments `frame_count`.
  - `tlast` is independent of lane alignment.
- Flush: when `channel_select` != `sel_q`, on the next edge clear `full`, `lane` and `wcnt`, and update `sel_q`. `frame_count` is preserved.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle completes normally; flush still applies afterwards.
- While `channel_select`==0: `s_axis_tready`=1, all input is dropped, and `full` stays 0. This is a buffer-flush mode.

## Timing
- Reset values:
  - `s_axis_tready`=1, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - `frame_count`=0, `full`=0, `lane`=0, `wcnt`=0.
  - `sel_q` = `channel_select` sampled in the reset cycle, so there is no spurious flush after reset.
- Latency: input handshake at edge N gives lane 0 valid at the output from N (registered), visible in cycle N+1.
- Throughput: with `m_axis_tready`=1 continuously, one output word per cycle and one input beat every `RATIO` cycles, with no bubble between beats.
- Reset asserted mid-drain: the partial word is discarded and all state returns to the reset values on that edge.
- Simultaneous flush and reload: flush wins and `full`=0 the next cycle.
- `wcnt` at `FRAME_BEATS`=1: `tlast` is asserted on every word.

## Test plan
- Reset, then push one beat 0x4444_4444_3333_3333_2222_2222_1111_1111 with `m_axis_tready`=1 → outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; `s_axis_tready` low for 3 cycles, then high.
- Continuous input of 256 beats with `FRAME_BEATS`=1024, `m_axis_tready`=1 → 1024 gap-free words; `tlast` on word 1023 only; `frame_count`=1.
- Random `m_axis_tready` backpressure (50%) over 1000 beats → scoreboarded output equals input lane-serialized; `tdata` stable whenever `tvalid`&!`tready`.
- Change `channel_select` from 0x0001 to 0x0002 after 2 lanes of a beat have drained → `m_axis_tvalid`=0 the next cycle; `wcnt` resets (the next `tlast` comes after `FRAME_BEATS` words); `frame_count` unchanged.
- `channel_select`=0 with 10 input beats → `s_axis_tready`=1 throughout; no output words; `frame_count` unchanged.
- Assert `rst` during lane 2 → all outputs at reset values the next cycle; a subsequent beat starts again at lane 0.
